mem_fifo_sched: RTL and testbench

Write-arbitration and read-sequencing controller for a memory core in FIFO mode (mode 1, tile enabled, chaining off). Two producers share the core's single write port through a round-robin arbiter. One consumer drains it through a ready/valid read port. The block owns the core's `clk_en`, `wen_in` and `ren_in` and tracks occupancy against a depth latched at start. The core itself never over-fills or under-runs.

---
 rtl/mem_fifo_sched_pkg.sv | 18 +
 rtl/mem_fifo_rr_arb.sv | 50 +++++
 rtl/mem_fifo_sched.sv | 191 +++++++++++++++++++
 tb/tb_mem_fifo_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fifo_sched_pkg.sv
// mem_fifo_sched_pkg
// Shared types and default widths for the FIFO-mode memory-core scheduler.
//   state_t  : controller state (IDLE, RUN, DRAIN)
//   rr_ptr_t : round-robin priority pointer (index of the producer holding priority)
package mem_fifo_sched_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int DEPTH_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef logic rr_ptr_t;

endpackage

// File: rtl/mem_fifo_rr_arb.sv
// mem_fifo_rr_arb
// Two-way round-robin write arbiter. The producer named by the pointer wins
// a tie; after any grant the pointer moves to the other producer.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-low reset
//   req_i[1:0]     : per-producer requests
//   en_i           : a grant may be given this cycle
//   gnt_o[1:0]     : one-hot grant (combinational)
module mem_fifo_rr_arb
    import mem_fifo_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    rr_ptr_t ptr_q;
    rr_ptr_t ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i[ptr_q]) begin
                gnt_o[ptr_q] = 1'b1;
            end else if (req_i[~ptr_q]) begin
                gnt_o[~ptr_q] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_fifo_sched.sv
// mem_fifo_sched
// Write arbitration and read sequencing for a memory core used as a FIFO.
// Two producers share the core write port via mem_fifo_rr_arb; one consumer
// drains it through a single-outstanding read port. Occupancy is tracked
// against the depth latched at start.
// Ports:
//   clk_i, reset_i             : clock, asynchronous active-low reset
//   start_i, drain_i, depth_i  : control and capacity
//   req_wen_i, req_data{0,1}_i : producer requests and data; req_gnt_o one-hot grant
//   rd_rdy_i, rd_data_o, rd_valid_o : consumer side
//   mem_*                      : memory core side
//   occupancy_o, full_o, empty_o, busy_o, err_o : status (err sticky until reset)
// Optional: MEM_FIFO_SCHED_PERF_EN adds saturating stall counters
//   stall_wr_cnt_o, stall_rd_cnt_o, cleared on start.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | core clock gated, waiting for start
// ST_RUN   | accepting writes and issuing reads
// ST_DRAIN | writes refused, reads continue until core is empty
module mem_fifo_sched
    import mem_fifo_sched_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH_W = DEPTH_W_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               drain_i,
    input  logic [DEPTH_W-1:0] depth_i,
    input  logic [1:0]         req_wen_i,
    input  logic [DATA_W-1:0]  req_data0_i,
    input  logic [DATA_W-1:0]  req_data1_i,
    output logic [1:0]         req_gnt_o,
    input  logic               rd_rdy_i,
    output logic [DATA_W-1:0]  rd_data_o,
    output logic               rd_valid_o,
    output logic               mem_clk_en_o,
    output logic               mem_wen_o,
    output logic [DATA_W-1:0]  mem_data_o,
    output logic               mem_ren_o,
    input  logic [DATA_W-1:0]  mem_data_out_i,
    input  logic               mem_valid_out_i,
    output logic [DEPTH_W-1:0] occupancy_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               busy_o,
    output logic               err_o
`ifdef MEM_FIFO_SCHED_PERF_EN
    ,
    output logic [31:0]        stall_wr_cnt_o,
    output logic [31:0]        stall_rd_cnt_o
`endif
);

    localparam logic [DEPTH_W-1:0] OCC_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

    state_t              state_q;
    logic [DEPTH_W-1:0]  depth_q;
    logic [DEPTH_W-1:0]  occ_q;
    logic [DEPTH_W-1:0]  occ_d;
    logic                out_q;
    logic                err_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                active;
    logic                wr_en;

    assign active = (state_q != ST_IDLE);

    // Only one read in flight; the core answers in the following cycle.
    assign mem_ren_o = active && rd_rdy_i && (occ_q != '0) && !out_q;

    // A concurrent read frees a slot, so a full FIFO can still take a write.
    assign wr_en = (state_q == ST_RUN) && ((occ_q < depth_q) || mem_ren_o);

    mem_fifo_rr_arb u_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req_i   (req_wen_i),
        .en_i    (wr_en),
        .gnt_o   (req_gnt_o)
    );

    assign mem_wen_o  = |req_gnt_o;
    assign mem_data_o = req_gnt_o[1] ? req_data1_i :
                        req_gnt_o[0] ? req_data0_i : '0;

    always_comb begin
        occ_d = occ_q;
        case ({mem_wen_o, mem_ren_o})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (depth_i == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            depth_q <= depth_i;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (drain_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((occ_q == '0) && !out_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Core failed to answer a read: flag it; out_q clears below regardless.
            if (out_q && !mem_valid_out_i) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            occ_q      <= '0;
            out_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            occ_q      <= occ_d;
            out_q      <= mem_ren_o;
            rd_valid_q <= out_q && mem_valid_out_i;
            if (out_q && mem_valid_out_i) begin
                rd_data_q <= mem_data_out_i;
            end
        end
    end

    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign occupancy_o  = occ_q;
    assign empty_o      = (occ_q == '0);
    // depth_q is zero only before the first valid start; keeps full low out of reset.
    assign full_o       = (depth_q != '0) && (occ_q == depth_q);
    assign busy_o       = active;
    assign mem_clk_en_o = active;
    assign err_o        = err_q;

`ifdef MEM_FIFO_SCHED_PERF_EN
    logic [31:0] stall_wr_q;
    logic [31:0] stall_rd_q;
    logic        stall_wr;
    logic        stall_rd;

    assign stall_wr = (state_q == ST_RUN) && (|req_wen_i) && (occ_q == depth_q) && !mem_ren_o;
    assign stall_rd = rd_rdy_i && empty_o;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_wr_q <= '0;
            stall_rd_q <= '0;
        end else if ((state_q == ST_IDLE) && start_i) begin
            stall_wr_q <= '0;
            stall_rd_q <= '0;
        end else begin
            if (stall_wr && (stall_wr_q != '1)) begin
                stall_wr_q <= stall_wr_q + 32'd1;
            end
            if (stall_rd && (stall_rd_q != '1)) begin
                stall_rd_q <= stall_rd_q + 32'd1;
            end
        end
    end

    assign stall_wr_cnt_o = stall_wr_q;
    assign stall_rd_cnt_o = stall_rd_q;
`endif

endmodule

// File: tb/tb_mem_fifo_sched.sv
// tb_mem_fifo_sched
// Directed bench for mem_fifo_sched with a behavioural one-cycle-latency core model.
module tb_mem_fifo_sched;

    logic        clk;
    logic        rst_n;
    logic        start, drain, rd_rdy;
    logic [15:0] depth;
    logic [1:0]  req;
    logic [15:0] d0, d1;
    logic [1:0]  gnt;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        clk_en, mem_wen, mem_ren;
    logic [15:0] mem_data;
    logic [15:0] mem_data_out;
    logic        mem_valid_out;
    logic [15:0] occ;
    logic        full, empty, busy, err;
`ifdef MEM_FIFO_SCHED_PERF_EN
    logic [31:0] stall_wr_cnt, stall_rd_cnt;
`endif

    logic        suppress;
    logic [15:0] core_q[$];
    logic [15:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    mem_fifo_sched dut (
        .clk_i           (clk),
        .reset_i         (rst_n),
        .start_i         (start),
        .drain_i         (drain),
        .depth_i         (depth),
        .req_wen_i       (req),
        .req_data0_i     (d0),
        .req_data1_i     (d1),
        .req_gnt_o       (gnt),
        .rd_rdy_i        (rd_rdy),
        .rd_data_o       (rd_data),
        .rd_valid_o      (rd_valid),
        .mem_clk_en_o    (clk_en),
        .mem_wen_o       (mem_wen),
        .mem_data_o      (mem_data),
        .mem_ren_o       (mem_ren),
        .mem_data_out_i  (mem_data_out),
        .mem_valid_out_i (mem_valid_out),
        .occupancy_o     (occ),
        .full_o          (full),
        .empty_o         (empty),
        .busy_o          (busy),
        .err_o           (err)
`ifdef MEM_FIFO_SCHED_PERF_EN
        ,
        .stall_wr_cnt_o  (stall_wr_cnt),
        .stall_rd_cnt_o  (stall_rd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory core: data and valid one cycle after a read enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_q.delete();
            mem_valid_out <= 1'b0;
            mem_data_out  <= '0;
        end else begin
            if (mem_ren && core_q.size() > 0) begin
                mem_data_out <= core_q.pop_front();
            end
            mem_valid_out <= mem_ren && !suppress;
            if (mem_wen) begin
                core_q.push_back(mem_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_occ"},    occ, 0);
        chk({tag, "_empty"},  empty, 1);
        chk({tag, "_full"},   full, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_clken"},  clk_en, 0);
        chk({tag, "_err"},    err, 0);
        chk({tag, "_gnt"},    gnt, 0);
        chk({tag, "_wen"},    mem_wen, 0);
        chk({tag, "_ren"},    mem_ren, 0);
        chk({tag, "_mdata"},  mem_data, 0);
        chk({tag, "_rvalid"}, rd_valid, 0);
        chk({tag, "_rdata"},  rd_data, 0);
    endtask

    task automatic start_run(input logic [15:0] dep);
        depth = dep;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Pulse drain, then keep both producers requesting and the consumer ready
    // until busy falls; checks read order, pulse count and busy timing.
    task automatic do_drain(input int n_exp);
        int n    = 0;
        int last = -1;
        int fall = -1;
        drain  = 1'b1;
        req    = 2'b00;
        rd_rdy = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            step();
            drain = 1'b0;
            req   = 2'b11;
            d0    = 16'hdead;
            d1    = 16'hbeef;
            #1;
            chk("drain_gnt", gnt, 0);
            if (rd_valid) begin
                n++;
                last = c;
                if (exp_q.size() > 0) chk("rd_data", rd_data, exp_q.pop_front());
            end
            if (!busy) begin
                fall = c;
                break;
            end
        end
        chk("rd_count", n, n_exp);
        chk("busy_fall", fall, last + 1);
        exp_q.delete();
        req    = 2'b00;
        rd_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; drain = 1'b0; rd_rdy = 1'b0; suppress = 1'b0;
        depth = '0; req = 2'b01; d0 = 16'h1234; d1 = 16'h5678;
        #3;
        chk_reset("rst");
        rst_n = 1'b1;
        step();
        req = 2'b00;

        // Run A: depth 4, producer 0 fills, fifth request refused.
        start_run(16'd4);
        #1;
        chk("a_busy", busy, 1);
        chk("a_clken", clk_en, 1);
        for (int i = 0; i < 4; i++) begin
            req = 2'b01;
            d0  = 16'h0100 + 16'(i);
            #1;
            chk("a_gnt", gnt, 2'b01);
            chk("a_mdata", mem_data, 16'h0100 + 16'(i));
            exp_q.push_back(16'h0100 + 16'(i));
            step();
        end
        req = 2'b01;
        #1;
        chk("a_gnt5", gnt, 2'b00);
        chk("a_occ4", occ, 4);
        chk("a_full", full, 1);
        chk("a_empty", empty, 0);
        // Full, consumer ready, producer 1 requesting.
        req = 2'b10; d1 = 16'h0200; rd_rdy = 1'b1;
        #1;
        chk("a_rw_gnt", gnt, 2'b10);
        chk("a_rw_ren", mem_ren, 1);
        chk("a_rw_wen", mem_wen, 1);
        exp_q.push_back(16'h0200);
        step();
        req = 2'b00; rd_rdy = 1'b0;
        #1;
        chk("a_rw_occ", occ, 4);
        chk("a_rw_full", full, 1);
        do_drain(5);

        // Run B: depth 8, both producers request, grants alternate.
        start_run(16'd8);
        for (int i = 0; i < 6; i++) begin
            req = 2'b11;
            d0  = 16'h1000 + 16'(i);
            d1  = 16'h2000 + 16'(i);
            #1;
            chk("b_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            exp_q.push_back((i % 2 == 0) ? 16'h1000 + 16'(i) : 16'h2000 + 16'(i));
            step();
        end
        req = 2'b00;
        #1;
        chk("b_occ", occ, 6);
        do_drain(6);

        // Run C: three words from producer 1, then drain.
        start_run(16'd8);
        for (int i = 0; i < 3; i++) begin
            req = 2'b10;
            d1  = 16'h0300 + 16'(i);
            #1;
            chk("c_gnt", gnt, 2'b10);
            exp_q.push_back(16'h0300 + 16'(i));
            step();
        end
        req = 2'b00;
        #1;
        chk("c_occ", occ, 3);
        do_drain(3);
        chk("c_err", err, 0);

        // start with drain in IDLE: RUN entered (a write is granted).
        depth = 16'd4; start = 1'b1; drain = 1'b1;
        step();
        start = 1'b0; drain = 1'b0; req = 2'b01; d0 = 16'h0055;
        #1;
        chk("sd_gnt", gnt, 2'b01);
        chk("sd_busy", busy, 1);
        step();
        // Suppressed core response raises err.
        req = 2'b00; rd_rdy = 1'b1; suppress = 1'b1;
        #1;
        chk("sup_ren", mem_ren, 1);
        step();
        rd_rdy = 1'b0;
        #1;
        chk("sup_err_pre", err, 0);
        step();
        chk("sup_err", err, 1);
        chk("sup_rvalid", rd_valid, 0);
        suppress = 1'b0;
        req = 2'b01; d0 = 16'h0066;
        #1;
        chk("mid_gnt", gnt, 2'b01);
        step();
        #1;
        chk("mid_occ", occ, 1);
        // Asynchronous reset between clock edges.
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        rst_n = 1'b1;
        req = 2'b00;
        step();

        // depth 0 start: error, stay idle.
        start_run(16'd0);
        #1;
        chk("z_err", err, 1);
        chk("z_busy", busy, 0);
        chk("z_clken", clk_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
